// File: rtl/mem_bus_ctrl.sv
// Bus interface unit: turns a one-cycle CPU request into an EN/RW/MFC memory cycle
// with a synchronised MFC, setup delay, timeout and a one-cycle acknowledge.
module mem_bus_ctrl #(
    parameter int unsigned AW        = 16,
    parameter int unsigned DW        = 16,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_err,
    output logic          busy,
    output logic          EN,
    output logic          RW,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          MFC
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [3:0] SETUP_LIM = 4'(SETUP_CYC);
    localparam logic [7:0] TO_LIM    = 8'(TIMEOUT);

    logic [2:0]    r_state;
    logic [2:0]    w_state_next;
    logic          r_mfc_meta;
    logic          r_mfc_s;
    logic [3:0]    r_setup_cnt;
    logic [7:0]    r_wait_cnt;
    logic [3:0]    w_setup_inc;
    logic [7:0]    w_wait_inc;
    logic          w_timeout;
    logic          r_err;
    logic          r_busy;
    logic          r_en;
    logic          r_rw;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;

    // Counters saturate; w_*_inc counts the current cycle as already spent.
    assign w_setup_inc = (r_setup_cnt == 4'hF) ? r_setup_cnt : r_setup_cnt + 4'd1;
    assign w_wait_inc  = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;
    assign w_timeout   = (TIMEOUT != 0) && (w_wait_inc >= TO_LIM);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (cpu_req) w_state_next = S_SETUP;
            S_SETUP:   if ((w_setup_inc >= SETUP_LIM) && !r_mfc_s) w_state_next = S_STROBE;
            S_STROBE:  if (r_mfc_s || w_timeout) w_state_next = S_RELEASE;
            S_RELEASE: if (!r_mfc_s || w_timeout) w_state_next = S_DONE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mfc_meta  <= 1'b0;
            r_mfc_s     <= 1'b0;
            r_setup_cnt <= 4'd0;
            r_wait_cnt  <= 8'd0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_en        <= 1'b0;
            r_rw        <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
        end else begin
            r_mfc_meta <= MFC;
            r_mfc_s    <= r_mfc_meta;
            r_state    <= w_state_next;
            if (w_state_next != r_state) begin
                r_setup_cnt <= 4'd0;
                r_wait_cnt  <= 8'd0;
            end else begin
                r_setup_cnt <= w_setup_inc;
                r_wait_cnt  <= w_wait_inc;
            end
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_rw    <= ~cpu_we;
                        r_busy  <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (w_state_next == S_STROBE) r_en <= 1'b1;
                end
                S_STROBE: begin
                    // MFC takes priority over a timeout landing on the same cycle.
                    if (r_mfc_s) begin
                        if (r_rw) r_rdata <= mem_rdata;
                        r_en <= 1'b0;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        r_en  <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    if (r_mfc_s && w_timeout) r_err <= 1'b1;
                end
                S_DONE: begin
                    r_busy <= 1'b0;
                    r_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign cpu_ack   = (r_state == S_DONE);
    assign cpu_err   = cpu_ack & r_err;
    assign cpu_rdata = r_rdata;
    assign busy      = r_busy;
    assign EN        = r_en;
    assign RW        = r_rw;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Bus interface unit between the CPU datapath (MAR/MDR side) and the asynchronous-handshake memory block.
- Converts a single-cycle CPU request into a full EN/RW/MFC memory cycle, then returns read data with a one-cycle acknowledge.
- Synchronises MFC into the clock domain and provides a timeout so a dead memory cannot hang the CPU.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- SETUP_CYC, 1, minimum cycles addr/RW/wdata held stable with EN low before EN rises (1..15).
- TIMEOUT, 255, maximum cycles waited in STROBE or RELEASE for an MFC edge. 0 disables the timeout.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- cpu_req  in  1  request strobe, sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_addr  in  AW  transaction address; sampled with cpu_req
- cpu_wdata  in  DW  write data; sampled with cpu_req
- cpu_rdata  out  DW  read data, valid from the ack cycle until the next read completes
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  one-cycle pulse coincident with cpu_ack when the transaction timed out
- busy  out  1  high from the cycle after acceptance through the ack cycle
- EN  out  1  memory enable; memory acts on its rising edge
- RW  out  1  1 = read, 0 = write (memory polarity)
- mem_addr  out  AW  address to memory
- mem_wdata  out  DW  data to memory Data_in
- mem_rdata  in  DW  data from memory Data_out
- MFC  in  1  memory function complete, asynchronous to clk

Behaviour:
- **Reset (rst_n=0 at a clk edge):**
  - EN=0, RW=1, mem_addr=0, mem_wdata=0, cpu_rdata=0, cpu_ack=0, cpu_err=0, busy=0.
  - State=IDLE, counters=0, both MFC synchroniser flops=0.
  - Reset mid-transaction drops EN the same edge and abandons the transaction with no ack.
- **MFC synchronisation:** two-flop synchroniser, mfc_s. All FSM decisions use mfc_s only.
- **FSM states:** IDLE, SETUP, STROBE, RELEASE, DONE.
- **IDLE:**
  - cpu_req=1 latches cpu_addr into mem_addr, cpu_wdata into mem_wdata, and RW=~cpu_we; sets busy=1; next state SETUP.
  - cpu_req=0 stays in IDLE.
- **SETUP:**
  - EN=0; count setup cycles.
  - Leave for STROBE when count ≥ SETUP_CYC AND mfc_s=0; a stale high MFC extends SETUP.
- **STROBE:**
  - EN=1.
  - On mfc_s=1: for a read, capture mem_rdata into cpu_rdata; next state RELEASE.
  - If the wait counter reaches TIMEOUT (TIMEOUT≠0): set the err flag, do not update cpu_rdata, go to RELEASE.
- **RELEASE:**
  - EN=0.
  - Wait for mfc_s=0, since memory clears MFC on the EN falling edge; then go to DONE.
  - The same TIMEOUT rule applies: timeout sets the err flag and goes to DONE.
- **DONE:**
  - cpu_ack=1 for exactly one cycle; cpu_err=err flag.
  - busy stays 1 this cycle and drops to 0 the next cycle.
  - Clear the err flag; next state IDLE.
- **Request timing:** a new cpu_req is accepted no earlier than the cycle after DONE. cpu_req asserted while busy=1 is ignored and not queued.
- **Stability:** mem_addr, RW and mem_wdata are held constant from SETUP through DONE. EN never rises in the same cycle these change.
- **Writes:** cpu_rdata unchanged; ack only signals completion.
- **Latency:** with req accepted at edge T and mfc_s rising k cycles after EN rises:
  - ack at T + SETUP_CYC + k + r + 2, where r = cycles for mfc_s to fall after EN falls.
  - r ≥ 2 because of the synchroniser.
- **Counters:**
  - Wait counter: 8 bits; saturating; cleared on every state change.
  - Setup counter: 4 bits.

Test Plan:
- **Read:** reset, then cpu_req=1, cpu_we=0, cpu_addr=16'h0003; memory returns 16'h0000 with MFC 10 ns after EN → EN high once, RW=1 throughout, cpu_ack one cycle, cpu_rdata=16'h0000, cpu_err=0, busy low the cycle after ack.
- **Write then read back:** write cpu_addr=16'h0020, cpu_wdata=16'hBEEF, then read 16'h0020 → first transaction RW=0 and mem_wdata=16'hBEEF at EN rise, cpu_rdata unchanged by the write; second read returns 16'hBEEF.
- **Timeout:** TIMEOUT=8 with MFC tied 0 → EN high exactly 8 cycles, then low; ack with cpu_err=1; cpu_rdata keeps its previous value.
- **Busy handling:** pulse cpu_req during STROBE with cpu_addr=16'h0005 → ignored; exactly one EN pulse and one ack for the original request.
- **Reset mid-operation:** assert rst_n=0 while in STROBE → next edge EN=0, busy=0, no ack. A request after reset release completes normally.
- **Stale MFC:** hold MFC=1 on entry to SETUP with SETUP_CYC=1 → EN stays low until mfc_s=0, then strobes normally.
